// File: rtl/ps2_mouse_pkg.sv
// Shared constants and types for the PS/2 mouse host side: command/response
// bytes, the init-controller state encoding and the 3-byte packet layout.
package ps2_mouse_pkg;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
  localparam logic [7:0] RSP_ID_STD  = 8'h00;

  localparam int TIMER_W = 26;

  typedef enum logic [2:0] {
    ST_SEND_RST,
    ST_WAIT_ACK1,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_SEND_EN,
    ST_WAIT_ACK2,
    ST_STREAM,
    ST_FAIL
  } ctrl_state_t;

  // Bit positions inside packet byte 0 (status byte).
  localparam int PKT_BTN_LEFT  = 0;
  localparam int PKT_BTN_RIGHT = 1;
  localparam int PKT_BTN_MID   = 2;
  localparam int PKT_ALWAYS1   = 3;
  localparam int PKT_X_SIGN    = 4;
  localparam int PKT_Y_SIGN    = 5;
  localparam int PKT_X_OVF     = 6;
  localparam int PKT_Y_OVF     = 7;
  localparam int PKT_BYTES     = 3;

  // States in which the per-state timeout is running.
  function automatic logic is_timed_state(input ctrl_state_t s);
    return (s != ST_STREAM) && (s != ST_FAIL);
  endfunction

endpackage

// File: rtl/ps2_mouse_init_ctrl_timer.sv
// Per-state timeout counter: load arms it with TIMEOUT_CYC, each enabled cycle
// counts down, and expired flags the enabled cycle in which the count reaches 0.
module ps2_timeout_timer
  import ps2_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TIMER_W'(TIMEOUT_CYC);
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= TIMER_W'(TIMEOUT_CYC);
    end else begin
      count_q <= count_d;
    end
  end

  // A state therefore lasts at most TIMEOUT_CYC cycles before the fault fires.
  assign expired = en && (count_q <= TIMER_W'(1));

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: reset, ACK/BAT/ID, enable reporting, ACK,
// then hand the rx stream to the packet decoder. Retries bounded by MAX_RETRY.
module ps2_mouse_init_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 25_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reinit,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic        stream_en,
  output logic        init_done,
  output logic        init_fail,
  output logic [1:0]  retry_cnt,
  output ctrl_state_t dbg_state
);

  // Handshakes: a byte is launched when a SEND state sees tx_ready=1; tx_start
  // is a registered one-cycle pulse with tx_data held until the next launch.
  // rx_valid and rx_err are single-cycle strobes; rx_err overrides rx_valid.

  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

  ctrl_state_t state_q, state_d, resend_state;
  logic [1:0]  retry_q, retry_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        stream_en_q, init_done_q, init_fail_q;
  logic        timer_load, timer_en, timer_expired;
  logic        fault, resend;
  logic [7:0]  want_byte;

  assign timer_en = is_timed_state(state_q);

  ps2_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    timer_load   = 1'b0;
    fault        = 1'b0;
    resend       = 1'b0;
    resend_state = ST_SEND_RST;
    want_byte    = (state_q == ST_WAIT_BAT) ? RSP_BAT_OK : RSP_ID_STD;

    if (reinit) begin
      state_d    = ST_SEND_RST;
      retry_d    = '0;
      timer_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_SEND_RST, ST_SEND_EN: begin
          // Received bytes and errors are dropped while we are still sending.
          if (tx_ready) begin
            tx_start_d = 1'b1;
            tx_data_d  = (state_q == ST_SEND_RST) ? CMD_RESET : CMD_ENABLE;
            state_d    = (state_q == ST_SEND_RST) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
            timer_load = 1'b1;
          end else if (timer_expired) begin
            fault = 1'b1;
          end
        end
        ST_WAIT_ACK1, ST_WAIT_ACK2: begin
          resend_state = (state_q == ST_WAIT_ACK1) ? ST_SEND_RST : ST_SEND_EN;
          if (rx_err) begin
            fault = 1'b1;
          end else if (rx_valid) begin
            if (rx_data == RSP_ACK) begin
              state_d    = (state_q == ST_WAIT_ACK1) ? ST_WAIT_BAT : ST_STREAM;
              timer_load = 1'b1;
            end else if (rx_data == RSP_RESEND) begin
              resend = 1'b1;
            end else begin
              fault = 1'b1;
            end
          end else if (timer_expired) begin
            fault = 1'b1;
          end
        end
        ST_WAIT_BAT, ST_WAIT_ID: begin
          if (rx_err) begin
            fault = 1'b1;
          end else if (rx_valid) begin
            if (rx_data == want_byte) begin
              state_d    = (state_q == ST_WAIT_BAT) ? ST_WAIT_ID : ST_SEND_EN;
              timer_load = 1'b1;
            end else begin
              fault = 1'b1;
            end
          end else if (timer_expired) begin
            fault = 1'b1;
          end
        end
        default: begin
          // STREAM and FAIL hold until reset or reinit.
        end
      endcase

      // A resend spends the same retry budget as any other fault.
      if (fault || resend) begin
        timer_load = 1'b1;
        if (retry_q == RETRY_LIMIT) begin
          state_d = ST_FAIL;
        end else begin
          retry_d = retry_q + 2'd1;
          state_d = resend ? resend_state : ST_SEND_RST;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SEND_RST;
      retry_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      stream_en_q <= 1'b0;
      init_done_q <= 1'b0;
      init_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      stream_en_q <= (state_d == ST_STREAM);
      init_done_q <= (state_d == ST_STREAM);
      init_fail_q <= (state_d == ST_FAIL);
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign stream_en = stream_en_q;
  assign init_done = init_done_q;
  assign init_fail = init_fail_q;
  assign retry_cnt = retry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Bench for ps2_mouse_init_ctrl: directed bring-up, fault and boundary steps,
// then random response sequences checked against a script-level model.
module tb_ps2_mouse_init_ctrl;
  import ps2_mouse_pkg::*;

  localparam int TO = 100;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        reset, reinit, tx_ready, rx_valid, rx_err;
  logic [7:0]  rx_data;
  logic        tx_start, stream_en, init_done, init_fail;
  logic [7:0]  tx_data;
  logic [1:0]  retry_cnt;
  ctrl_state_t dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int tx_seen     = 0;

  always #5 clk = ~clk;

  ps2_mouse_init_ctrl #(
    .TIMEOUT_CYC(TO),
    .MAX_RETRY  (MR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reinit   (reinit),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .stream_en(stream_en),
    .init_done(init_done),
    .init_fail(init_fail),
    .retry_cnt(retry_cnt),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All waiting happens at falling edges so outputs are stable when sampled.
  task automatic tick();
    @(negedge clk);
    if (tx_start === 1'b1) tx_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_err   = err;
    tick();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp_data, input int budget,
                         output int waited);
    bit found;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < budget) begin
      tick();
      waited++;
      if (tx_start === 1'b1) found = 1'b1;
    end
    check({tag, "_start"}, 32'(found), 32'd1);
    if (found) check({tag, "_data"}, 32'(tx_data), 32'(exp_data));
  endtask

  // Response the bring-up script expects at each waiting position.
  function automatic logic [7:0] resp_for(input int pos);
    case (pos)
      1:       return RSP_ACK;
      2:       return RSP_BAT_OK;
      3:       return RSP_ID_STD;
      default: return RSP_ACK;
    endcase
  endfunction

  initial begin
    int w, n, t0, pos, m_retry, kind, idle;
    bit done, failed;
    logic [7:0] want, b;
    logic e;

    reset = 1'b1; reinit = 1'b0; tx_ready = 1'b1;
    rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;

    // Reset values
    repeat (3) tick();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_stream_en", 32'(stream_en), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_init_fail", 32'(init_fail), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_SEND_RST));
    reset = 1'b0;

    // Nominal bring-up
    wait_tx("nom_ff", CMD_RESET, 3, w);
    check("nom_ff_lat", 32'(w), 32'd1);
    send_byte(RSP_ACK, 1'b0);
    send_byte(RSP_BAT_OK, 1'b0);
    send_byte(RSP_ID_STD, 1'b0);
    wait_tx("nom_f4", CMD_ENABLE, 3, w);
    check("nom_f4_lat", 32'(w), 32'd1);
    tick();
    check("nom_pulse_one", 32'(tx_start), 32'd0);
    check("nom_data_hold", 32'(tx_data), 32'(CMD_ENABLE));
    send_byte(RSP_ACK, 1'b0);
    check("nom_done", 32'(init_done), 32'd1);
    check("nom_stream", 32'(stream_en), 32'd1);
    check("nom_fail", 32'(init_fail), 32'd0);
    check("nom_retry", 32'(retry_cnt), 32'd0);
    t0 = tx_seen;
    send_byte(RSP_RESEND, 1'b0);
    send_byte(8'h08, 1'b1);
    repeat (3) tick();
    check("strm_ignore_done", 32'(init_done), 32'd1);
    check("strm_ignore_retry", 32'(retry_cnt), 32'd0);
    check("strm_no_tx", 32'(tx_seen - t0), 32'd0);

    // reinit from STREAM
    pulse_reinit();
    check("reinit_strm_stream", 32'(stream_en), 32'd0);
    check("reinit_strm_done", 32'(init_done), 32'd0);
    check("reinit_strm_retry", 32'(retry_cnt), 32'd0);
    wait_tx("reinit_strm_ff", CMD_RESET, 2, w);
    check("reinit_strm_lat", 32'(w), 32'd1);

    // Resend of FF
    send_byte(RSP_RESEND, 1'b0);
    check("resend_retry", 32'(retry_cnt), 32'd1);
    wait_tx("resend_ff", CMD_RESET, 3, w);
    send_byte(RSP_ACK, 1'b0);
    send_byte(RSP_BAT_OK, 1'b0);
    send_byte(RSP_ID_STD, 1'b0);
    wait_tx("resend_f4", CMD_ENABLE, 3, w);
    send_byte(RSP_ACK, 1'b0);
    check("resend_done", 32'(init_done), 32'd1);
    check("resend_retry_kept", 32'(retry_cnt), 32'd1);

    // BAT error, then rx_err in WAIT_ID
    pulse_reinit();
    wait_tx("bat_ff", CMD_RESET, 2, w);
    send_byte(RSP_ACK, 1'b0);
    send_byte(RSP_BAT_ERR, 1'b0);
    check("bat_retry", 32'(retry_cnt), 32'd1);
    wait_tx("bat_restart", CMD_RESET, 2, w);
    send_byte(RSP_ACK, 1'b0);
    send_byte(RSP_BAT_OK, 1'b0);
    send_byte(RSP_ID_STD, 1'b1);
    check("iderr_retry", 32'(retry_cnt), 32'd2);
    wait_tx("iderr_restart", CMD_RESET, 2, w);

    // Timeout exhaustion: no responses at all
    pulse_reinit();
    wait_tx("to_first", CMD_RESET, 2, w);
    for (int k = 1; k <= 3; k++) begin
      wait_tx("to_restart", CMD_RESET, TO + 20, w);
      check("to_spacing", 32'(w), 32'(TO + 1));
      check("to_retry", 32'(retry_cnt), 32'(k));
    end
    n = 0;
    while (init_fail !== 1'b1 && n < TO + 20) begin
      tick();
      n++;
    end
    check("to_fail_lat", 32'(n), 32'(TO));
    check("to_fail", 32'(init_fail), 32'd1);
    check("to_fail_done", 32'(init_done), 32'd0);
    check("to_fail_retry", 32'(retry_cnt), 32'd3);
    t0 = tx_seen;
    repeat (150) tick();
    check("to_fail_quiet", 32'(tx_seen - t0), 32'd0);
    check("to_fail_hold", 32'(init_fail), 32'd1);

    // reinit from FAIL
    pulse_reinit();
    check("reinit_fail_fail", 32'(init_fail), 32'd0);
    check("reinit_fail_retry", 32'(retry_cnt), 32'd0);
    wait_tx("reinit_fail_ff", CMD_RESET, 2, w);

    // ACK arriving in the very cycle the timer runs out is accepted
    repeat (TO - 1) tick();
    send_byte(RSP_ACK, 1'b0);
    check("edge_ack_retry", 32'(retry_cnt), 32'd0);
    send_byte(RSP_BAT_OK, 1'b0);
    send_byte(RSP_ID_STD, 1'b0);
    wait_tx("edge_ack_f4", CMD_ENABLE, 3, w);
    check("edge_ack_retry2", 32'(retry_cnt), 32'd0);

    // One cycle later the timeout has already won
    pulse_reinit();
    wait_tx("late_ff", CMD_RESET, 2, w);
    repeat (TO) tick();
    send_byte(RSP_ACK, 1'b0);
    check("late_ack_retry", 32'(retry_cnt), 32'd1);
    check("late_ack_restart", 32'(tx_start), 32'd1);

    // tx_ready held low in SEND_RST
    tx_ready = 1'b0;
    pulse_reinit();
    t0 = tx_seen;
    repeat (TO - 1) tick();
    check("rdy_low_before", 32'(retry_cnt), 32'd0);
    tick();
    check("rdy_low_retry", 32'(retry_cnt), 32'd1);
    check("rdy_low_no_tx", 32'(tx_seen - t0), 32'd0);
    tx_ready = 1'b1;
    wait_tx("rdy_low_ff", CMD_RESET, 2, w);
    check("rdy_low_lat", 32'(w), 32'd1);

    // reset together with reinit behaves as reset
    send_byte(RSP_RESEND, 1'b0);
    wait_tx("rr_pre_ff", CMD_RESET, 3, w);
    check("rr_pre_retry", 32'(retry_cnt), 32'd2);
    reset = 1'b1;
    reinit = 1'b1;
    tick();
    check("rr_tx_data", 32'(tx_data), 32'h00);
    check("rr_retry", 32'(retry_cnt), 32'd0);
    check("rr_tx_start", 32'(tx_start), 32'd0);
    reset = 1'b0;
    reinit = 1'b0;
    wait_tx("rr_ff", CMD_RESET, 2, w);
    check("rr_lat", 32'(w), 32'd1);

    // Random response sequences against the script model
    for (int trial = 0; trial < 12; trial++) begin
      pulse_reinit();
      pos = 0; m_retry = 0; done = 1'b0; failed = 1'b0;
      for (int s = 0; s < 24 && !done && !failed; s++) begin
        if (pos == 0 || pos == 4) begin
          wait_tx("rnd_cmd", (pos == 0) ? CMD_RESET : CMD_ENABLE, 4, w);
          pos++;
        end else begin
          want = resp_for(pos);
          kind = $urandom_range(0, 9);
          idle = $urandom_range(0, 4);
          repeat (idle) tick();
          b = want;
          e = 1'b0;
          if (kind == 6) begin
            b = RSP_RESEND;
          end else if (kind == 7) begin
            do b = 8'($urandom); while (b == want || b == RSP_RESEND);
          end else if (kind == 8) begin
            e = 1'b1;
          end
          if (kind == 9) begin
            rx_err = 1'b1;
            tick();
            rx_err = 1'b0;
          end else begin
            send_byte(b, e);
          end
          if (kind <= 5) begin
            pos++;
            if (pos == 6) done = 1'b1;
          end else if (m_retry == MR) begin
            failed = 1'b1;
          end else begin
            m_retry++;
            pos = (kind == 6 && (pos == 1 || pos == 5)) ? pos - 1 : 0;
          end
          check("rnd_retry", 32'(retry_cnt), 32'(m_retry));
          check("rnd_done", 32'(init_done), 32'(done));
          check("rnd_stream", 32'(stream_en), 32'(done));
          check("rnd_fail", 32'(init_fail), 32'(failed));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
